// File: rtl/apb_rr_bridge.sv
// apb_rr_bridge: lets two local requesters share one APB bus.
// A round-robin arbiter picks the owner in IDLE. The FSM then runs the
// SETUP and ACCESS phases, waits for PREADY, and aborts the transfer if
// PREADY stays low for TIMEOUT ACCESS cycles. The RESP cycle reports the
// result to the owner with a one-cycle done pulse.
module apb_rr_bridge #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              m0_req,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  input  logic              m1_req,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  // The wait counter can hold TIMEOUT itself and saturates instead of wrapping.
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Count value reached on the last ACCESS cycle that is allowed to stall.
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             owner;     // 0 = m0, 1 = m1 for the current transfer
  logic             last;      // owner of the most recently completed transfer
  logic             any_req;
  logic             pick;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + CNT_W'(1);
  endfunction

  // Round-robin choice: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    any_req = m0_req | m1_req;
    if (m0_req && m1_req) pick = ~last;
    else                  pick = m1_req;
  end

  // Transfer sequencer; every bus and handshake output is registered here.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      owner     <= 1'b0;
      last      <= 1'b1;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_done   <= 1'b0;
      m1_done   <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner  <= pick;
            PWRITE <= pick ? m1_write : m0_write;
            PADDR  <= pick ? m1_addr  : m0_addr;
            PWDATA <= pick ? m1_wdata : m0_wdata;
            m0_gnt <= ~pick;
            m1_gnt <= pick;
            PSEL   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          wait_cnt <= '0;
          PENABLE  <= 1'b1;
          state    <= ACCESS;
        end
        ACCESS: begin
          // PREADY takes priority over the timeout on the final allowed cycle.
          if (PREADY || wait_cnt == LAST_WAIT) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            m0_done   <= ~owner;
            m1_done   <= owner;
            rsp_err   <= ~PREADY;
            rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
            state     <= RESP;
          end else begin
            wait_cnt <= sat_inc(wait_cnt);
          end
        end
        RESP: begin
          m0_done <= 1'b0;
          m1_done <= 1'b0;
          m0_gnt  <= 1'b0;
          m1_gnt  <= 1'b0;
          last    <= owner;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_bridge.sv
// Testbench for apb_rr_bridge: directed scenarios plus randomized transfers,
// checked against a transaction-level reference model. The model tracks the
// round-robin owner and the expected outcome of each transfer.
module tb_apb_rr_bridge;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int TMO = 4;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          m0_req, m0_write, m0_gnt, m0_done;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m1_req, m1_write, m1_gnt, m1_done;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSEL, PENABLE, PWRITE, PREADY;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  int checks = 0;
  int errors = 0;
  logic model_last;   // reference model: 1 when m1 owned the last completed transfer

  // Observations collected by serve() for one transfer
  int            obs_idle, obs_acc;
  logic          obs_setup_ok, obs_g0, obs_g1, obs_write, obs_hold;
  logic          obs_d0, obs_d1, obs_resp_bus, obs_resp_gnt, obs_err, obs_after_clean;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_wdata, obs_rdata;

  always #5 PCLK = ~PCLK;

  apb_rr_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  // Bus rules that hold on every cycle out of reset
  always @(negedge PCLK) begin
    if (!PRESET) begin
      checks++;
      if ((PENABLE && !PSEL) || (m0_gnt && m1_gnt)) begin
        errors++;
        $display("FAIL protocol: PSEL=%b PENABLE=%b m0_gnt=%b m1_gnt=%b, required PENABLE->PSEL and at most one gnt",
                 PSEL, PENABLE, m0_gnt, m1_gnt);
      end
    end
  end

  // Reference model of a transfer: ACCESS cycles and the error flag from the PREADY stall length
  function automatic int exp_acc(input int waits);
    return (waits >= TMO) ? TMO : waits + 1;
  endfunction

  function automatic logic exp_err(input int waits);
    return waits >= TMO;
  endfunction

  // Acts as the APB slave for one transfer and records what the bridge did.
  // Called #1 after a rising edge while the bridge is idle.
  task automatic serve(input int waits, input logic [DW-1:0] rdv, input logic keep, input logic mutate);
    int n;
    n = 0;
    PREADY = 1'b0;
    while (!PSEL && n < 20) begin
      @(posedge PCLK); #1;
      n++;
    end
    obs_idle     = n;
    obs_setup_ok = PSEL && !PENABLE;
    obs_g0       = m0_gnt;
    obs_g1       = m1_gnt;
    obs_addr     = PADDR;
    obs_write    = PWRITE;
    obs_wdata    = PWDATA;
    obs_hold     = 1'b1;
    obs_acc      = 0;
    @(posedge PCLK); #1;
    while (PSEL && PENABLE && obs_acc < 40) begin
      obs_acc++;
      if (PADDR !== obs_addr || PWRITE !== obs_write || PWDATA !== obs_wdata) obs_hold = 1'b0;
      if (mutate && obs_acc == 1) begin
        m0_addr  = m0_addr + 8'h02;
        m1_addr  = m1_addr + 8'h02;
        m0_wdata = ~m0_wdata;
        m1_wdata = ~m1_wdata;
        m0_write = ~m0_write;
        m1_write = ~m1_write;
        m0_req   = 1'b0;
        m1_req   = 1'b0;
      end
      PREADY = (obs_acc > waits);
      PRDATA = PREADY ? rdv : DW'($urandom);
      @(posedge PCLK); #1;
    end
    PREADY       = 1'b0;
    PRDATA       = '0;
    obs_resp_bus = PSEL | PENABLE;
    obs_d0       = m0_done;
    obs_d1       = m1_done;
    obs_rdata    = rsp_rdata;
    obs_err      = rsp_err;
    obs_resp_gnt = obs_g1 ? m1_gnt : m0_gnt;
    if (!keep) begin
      if (obs_g1) m1_req = 1'b0;
      else        m0_req = 1'b0;
    end
    @(posedge PCLK); #1;
    obs_after_clean = !(m0_done | m1_done | m0_gnt | m1_gnt);
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    m0_req = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0;
    PREADY = 0; PRDATA = '0;
    repeat (2) @(posedge PCLK);
    #1;
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, m0_gnt, m1_gnt, m0_done, m1_done, rsp_rdata, rsp_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: PSEL=%b PENABLE=%b PWRITE=%b PADDR=%h PWDATA=%h gnt=%b%b done=%b%b rdata=%h err=%b, required all 0",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA, m0_gnt, m1_gnt, m0_done, m1_done, rsp_rdata, rsp_err);
    end
    PRESET = 1'b0;
    model_last = 1'b1;
    @(posedge PCLK); #1;
  endtask

  task automatic test_single_write();
    m0_req = 1; m0_write = 1; m0_addr = 8'h00; m0_wdata = 8'hAA;
    serve(0, 8'h00, 1'b0, 1'b0);
    model_last = 1'b0;
    checks++;
    if (!(obs_setup_ok && obs_idle == 1 && obs_acc == 1)) begin
      errors++;
      $display("FAIL write_phases: setup_ok=%b idle=%0d access=%0d, required 1/1/1", obs_setup_ok, obs_idle, obs_acc);
    end
    checks++;
    if ({obs_g0, obs_g1, obs_write, obs_addr, obs_wdata} !== {1'b1, 1'b0, 1'b1, 8'h00, 8'hAA}) begin
      errors++;
      $display("FAIL write_bus: gnt=%b%b PWRITE=%b PADDR=%h PWDATA=%h, required gnt=10 PWRITE=1 PADDR=00 PWDATA=aa",
               obs_g0, obs_g1, obs_write, obs_addr, obs_wdata);
    end
    checks++;
    if ({obs_d0, obs_d1, obs_err, obs_rdata, obs_resp_bus, obs_resp_gnt, obs_after_clean} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL write_resp: done=%b%b err=%b rdata=%h bus=%b gnt_in_resp=%b clean_after=%b, required 10 0 00 0 1 1",
               obs_d0, obs_d1, obs_err, obs_rdata, obs_resp_bus, obs_resp_gnt, obs_after_clean);
    end
  endtask

  task automatic test_wait_read();
    m1_req = 1; m1_write = 0; m1_addr = 8'h02; m1_wdata = 8'h11;
    serve(3, 8'hCC, 1'b0, 1'b0);
    model_last = 1'b1;
    checks++;
    if ({obs_g1, obs_write, obs_addr} !== {1'b1, 1'b0, 8'h02} || obs_acc != exp_acc(3)) begin
      errors++;
      $display("FAIL read_wait_bus: gnt1=%b PWRITE=%b PADDR=%h access=%0d, required 1 0 02 %0d",
               obs_g1, obs_write, obs_addr, obs_acc, exp_acc(3));
    end
    checks++;
    if ({obs_d0, obs_d1, obs_err, obs_rdata} !== {1'b0, 1'b1, 1'b0, 8'hCC}) begin
      errors++;
      $display("FAIL read_wait_resp: done=%b%b err=%b rdata=%h, required 01 0 cc", obs_d0, obs_d1, obs_err, obs_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_owner;
    m0_req = 1; m0_write = 1; m0_wdata = 8'h5A;
    m1_req = 1; m1_write = 0; m1_wdata = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      m0_addr = 8'h10 + 8'(i);
      m1_addr = 8'h20 + 8'(i);
      exp_owner = ~model_last;
      serve(i % 2, 8'h30 + 8'(i), 1'b1, 1'b0);
      checks++;
      if (obs_g1 !== exp_owner || obs_g0 !== ~exp_owner || obs_idle != 1 ||
          obs_addr !== (exp_owner ? m1_addr : m0_addr) || obs_d1 !== exp_owner || obs_d0 !== ~exp_owner) begin
        errors++;
        $display("FAIL rr_order[%0d]: gnt=%b%b idle=%0d PADDR=%h done=%b%b, required owner m%0d idle=1",
                 i, obs_g0, obs_g1, obs_idle, obs_addr, obs_d0, obs_d1, exp_owner);
      end
      model_last = exp_owner;
    end
    m0_req = 0; m1_req = 0;
    @(posedge PCLK); #1;
  endtask

  task automatic test_timeout();
    int wl [3];
    logic [DW-1:0] rdv;
    wl[0] = 99; wl[1] = TMO; wl[2] = TMO - 1;
    for (int i = 0; i < 3; i++) begin
      rdv = 8'h5A + 8'(i);
      m0_req = 1; m0_write = 0; m0_addr = 8'h05; m0_wdata = 8'h00;
      serve(wl[i], rdv, 1'b0, 1'b0);
      model_last = 1'b0;
      checks++;
      if (obs_acc != exp_acc(wl[i]) || obs_err !== exp_err(wl[i]) ||
          obs_rdata !== (exp_err(wl[i]) ? 8'h00 : rdv) || obs_d0 !== 1'b1 || obs_resp_bus !== 1'b0) begin
        errors++;
        $display("FAIL timeout[%0d]: access=%0d err=%b rdata=%h done0=%b bus=%b, required %0d %b %h 1 0",
                 i, obs_acc, obs_err, obs_rdata, obs_d0, obs_resp_bus,
                 exp_acc(wl[i]), exp_err(wl[i]), exp_err(wl[i]) ? 8'h00 : rdv);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    m1_req = 1; m1_write = 0; m1_addr = 8'h07;
    PREADY = 0;
    @(posedge PCLK); #1;   // SETUP
    @(posedge PCLK); #1;   // ACCESS
    #1;
    PRESET = 1'b1;
    #1;
    checks++;
    if ({PSEL, PENABLE, m1_gnt} !== 3'b000) begin
      errors++;
      $display("FAIL reset_async: PSEL=%b PENABLE=%b m1_gnt=%b before next edge, required 000", PSEL, PENABLE, m1_gnt);
    end
    m1_req = 0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    model_last = 1'b1;
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge PCLK); #1;
      if (m0_done || m1_done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: done seen=%b after mid-transfer reset, required 0", saw_done);
    end
    m0_req = 1; m0_write = 1; m0_addr = 8'h33;
    m1_req = 1; m1_write = 1; m1_addr = 8'h44;
    serve(0, 8'h00, 1'b0, 1'b0);
    model_last = 1'b0;
    m1_req = 0;
    checks++;
    if ({obs_g0, obs_g1, obs_addr} !== {1'b1, 1'b0, 8'h33}) begin
      errors++;
      $display("FAIL reset_tie: gnt=%b%b PADDR=%h, required gnt=10 PADDR=33", obs_g0, obs_g1, obs_addr);
    end
    @(posedge PCLK); #1;
  endtask

  task automatic test_addr_hold();
    m0_req = 1; m0_write = 0; m0_addr = 8'h01; m0_wdata = 8'h77;
    serve(2, 8'h9E, 1'b0, 1'b1);
    model_last = 1'b0;
    checks++;
    if (obs_addr !== 8'h01 || obs_hold !== 1'b1 || m0_addr !== 8'h03) begin
      errors++;
      $display("FAIL addr_hold: PADDR=%h held=%b m0_addr=%h, required 01 1 03", obs_addr, obs_hold, m0_addr);
    end
    checks++;
    if ({obs_d0, obs_err, obs_rdata} !== {1'b1, 1'b0, 8'h9E} || obs_acc != exp_acc(2)) begin
      errors++;
      $display("FAIL drop_req_done: done0=%b err=%b rdata=%h access=%0d, required 1 0 9e %0d",
               obs_d0, obs_err, obs_rdata, obs_acc, exp_acc(2));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int r, w;
      logic own, ew;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed, rdv;
      r = $urandom_range(1, 3);
      w = $urandom_range(0, 5);
      rdv = DW'($urandom);
      m0_write = 1'($urandom); m0_addr = AW'($urandom); m0_wdata = DW'($urandom);
      m1_write = 1'($urandom); m1_addr = AW'($urandom); m1_wdata = DW'($urandom);
      m0_req = r[0]; m1_req = r[1];
      own = (r == 3) ? ~model_last : (r == 2);
      ew  = own ? m1_write : m0_write;
      ea  = own ? m1_addr  : m0_addr;
      ed  = own ? m1_wdata : m0_wdata;
      serve(w, rdv, 1'b0, 1'b0);
      model_last = own;
      checks++;
      if (obs_g1 !== own || obs_g0 !== ~own || obs_write !== ew || obs_addr !== ea || obs_wdata !== ed ||
          obs_idle != 1 || !obs_setup_ok || !obs_hold) begin
        errors++;
        $display("FAIL rand_req[%0d]: gnt=%b%b PWRITE=%b PADDR=%h PWDATA=%h idle=%0d setup=%b hold=%b, required owner m%0d %b %h %h 1 1 1",
                 i, obs_g0, obs_g1, obs_write, obs_addr, obs_wdata, obs_idle, obs_setup_ok, obs_hold, own, ew, ea, ed);
      end
      checks++;
      if (obs_acc != exp_acc(w) || obs_err !== exp_err(w) || obs_rdata !== ((ew || exp_err(w)) ? 8'h00 : rdv) ||
          obs_d1 !== own || obs_d0 !== ~own || obs_resp_bus !== 1'b0 || !obs_after_clean) begin
        errors++;
        $display("FAIL rand_resp[%0d]: access=%0d err=%b rdata=%h done=%b%b bus=%b clean=%b, required %0d %b %h owner m%0d",
                 i, obs_acc, obs_err, obs_rdata, obs_d0, obs_d1, obs_resp_bus, obs_after_clean,
                 exp_acc(w), exp_err(w), (ew || exp_err(w)) ? 8'h00 : rdv, own);
      end
    end
    m0_req = 0; m1_req = 0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_wait_read();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_addr_hold();
    test_random();
    repeat (2) @(posedge PCLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_rr_bridge.md
Name: apb_rr_bridge

Overview:
- Two-requester APB master controller that shares one APB bus between two local requesters (m0, m1).
- Round-robin arbitration picks the owner of each transfer.
- Sequences the APB SETUP/ACCESS phases and handles PREADY wait states.
- Aborts a stalled transfer after a programmable timeout. Sits between CPU-side request ports and the APB peripheral register bank.

Parameters:
- ADDR_W, 8, width of request and PADDR address.
- DATA_W, 8, width of write/read data.
- TIMEOUT, 16, maximum ACCESS cycles without PREADY before abort (valid range 1..255).

Ports:
- PCLK  in  1  clock, rising-edge.
- PRESET  in  1  asynchronous, active-high reset.
- m0_req  in  1  level request; held high with fields stable until m0_done.
- m0_write  in  1  1=write, 0=read.
- m0_addr  in  ADDR_W  target address.
- m0_wdata  in  DATA_W  write data.
- m0_gnt  out  1  m0 owns the bus (SETUP through RESP).
- m0_done  out  1  one-cycle completion pulse.
- m1_req, m1_write, m1_addr, m1_wdata, m1_gnt, m1_done: same as m0.
- rsp_rdata  out  DATA_W  read data of the completed transfer, valid while any done=1.
- rsp_err  out  1  completed transfer timed out, valid while any done=1.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready.

Behaviour:

Reset:
- On PRESET, asynchronously clear PSEL, PENABLE, PWRITE, PADDR, PWDATA, gnt, done, rsp_rdata and rsp_err to 0.
- Set the round-robin pointer last=1, so m0 wins the first tie.
- FSM goes to IDLE. Reset mid-transfer drops PSEL/PENABLE immediately and generates no done.

FSM states (all outputs registered):
- IDLE: PSEL=0, PENABLE=0.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester that is not `last`.
  - On grant: latch write/addr/wdata into PWRITE/PADDR/PWDATA, set gnt, go to SETUP. Otherwise stay.
- SETUP: PSEL=1, PENABLE=0 for exactly one cycle. Clear the wait counter. Go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA are held.
  - PREADY=1 at a rising edge: capture PRDATA into rsp_rdata if a read, else rsp_rdata=0. Set rsp_err=0, go to RESP.
  - PREADY=0: increment the wait counter. When the count reaches TIMEOUT, abort: go to RESP with rsp_err=1, rsp_rdata=0.
  - If PREADY=1 on the TIMEOUT-th cycle, the transfer succeeds (PREADY wins).
- RESP: PSEL=0, PENABLE=0. Assert the owner's done for exactly one cycle; gnt stays high. Update last=owner. Clear gnt and go to IDLE. Requests are ignored in RESP.

Timing and requester rules:
- Minimum transfer: request seen in IDLE, then SETUP, ACCESS, RESP, giving done 3 cycles after the grant edge, with zero wait states.
- There is 1 IDLE cycle between back-to-back transfers.
- The requester must deassert req (or present the next request) at the edge ending RESP.
- A req that stays high after done is treated as a new request in IDLE.
- Requester fields changing while granted are ignored, because they were latched at grant.
- Deasserting req during SETUP/ACCESS does not cancel the transfer; done still pulses.

Other rules:
- PSEL/PENABLE never both 1 outside ACCESS; PENABLE=1 implies PSEL=1.
- The wait counter is wide enough for TIMEOUT and saturates; it has no wrap-around.
- Fairness: with both requesters continuously requesting, grants alternate m0, m1, m0, ...

Test Plan:
1. Reset, then m0 writes addr 0x00 data 0xAA with PREADY=1 constant -> PSEL high 1 cycle before PENABLE; PADDR=0x00, PWDATA=0xAA, PWRITE=1; m0_done pulses once; rsp_err=0.
2. After writes, m1 reads addr 0x02 with PREADY low for 3 ACCESS cycles and PRDATA=0xCC on the ready cycle -> 4 ACCESS cycles; rsp_rdata=0xCC on m1_done; m0_done stays 0.
3. m0 and m1 request simultaneously and stay high for 4 transfers -> grant order m0, m1, m0, m1; exactly one gnt high at a time; one IDLE cycle between transfers.
4. TIMEOUT=4, PREADY held 0 -> abort after 4 ACCESS cycles; done with rsp_err=1, rsp_rdata=0x00; PSEL returns to 0. A variant with PREADY=1 on the 4th cycle -> rsp_err=0.
5. Assert PRESET during ACCESS of an m1 read -> PSEL/PENABLE/gnt go 0 without waiting for a clock edge; no done; after release, m0/m1 tie is granted to m0.
6. The granted requester changes m0_addr from 0x01 to 0x03 during ACCESS -> PADDR holds 0x01 until RESP.
